// File: rtl/upsample_pkg.sv
// -----------------------------------------------------------------------------
// upsample_pkg
// Shared definitions for the upsampler frame sequencer and its bench:
//   - state_t : sequencer state encoding (IDLE=0, FEED=1, DRAIN=2, GAP=3)
//   - DEF_*   : default geometry/timing constants
// -----------------------------------------------------------------------------
package upsample_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FEED  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   localparam int DEF_DATA_WIDTH     = 32;
   localparam int DEF_CNT_WIDTH      = 16;
   localparam int DEF_GAP_CYCLES     = 20;
   localparam int DEF_V_SCALE        = 2;
   localparam int DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/upsample_geom_cnt.sv
// -----------------------------------------------------------------------------
// upsample_geom_cnt
// Word/line position counter for one input frame.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   clear           : synchronous clear of both counters (frame start)
//   advance         : one accepted word
//   words_per_line  : latched line length (nonzero)
//   lines           : latched line count (nonzero)
//   last_word       : current word is the final word of its line
//   last_line       : current line is the final line of the frame
// -----------------------------------------------------------------------------
module upsample_geom_cnt #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 advance,
   input  logic [CNT_WIDTH-1:0] words_per_line,
   input  logic [CNT_WIDTH-1:0] lines,
   output logic                 last_word,
   output logic                 last_line
);

   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
   logic [CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;

   assign last_word = (word_cnt_q == words_per_line - ONE);
   assign last_line = (line_cnt_q == lines - ONE);

   always_comb begin
      word_cnt_d = word_cnt_q;
      line_cnt_d = line_cnt_q;
      if (clear) begin
         word_cnt_d = '0;
         line_cnt_d = '0;
      end else if (advance) begin
         if (last_word) begin
            word_cnt_d = '0;
            line_cnt_d = line_cnt_q + ONE;
         end else begin
            word_cnt_d = word_cnt_q + ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt_q <= '0;
         line_cnt_q <= '0;
      end else begin
         word_cnt_q <= word_cnt_d;
         line_cnt_q <= line_cnt_d;
      end
   end

endmodule

// File: rtl/upsample_frame_sched.sv
// -----------------------------------------------------------------------------
// upsample_frame_sched
// Frame sequencer in front of the Bayes upsampler. Admits exactly one frame of
// the DMA stream, regenerates per-line tlast from the programmed geometry,
// waits until the upscaled frame has drained from the upsampler output, holds
// an idle gap, then pulses done.
//
// Optional feature macro: DRAIN_TIMEOUT_EN
//   defined   : a drain stall counter forces GAP and sets err_timeout after
//               TIMEOUT_CYCLES cycles without an output handshake
//   undefined : DRAIN waits indefinitely, err_timeout tied 0
//
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   cfg_words_per_line, cfg_lines : frame geometry, latched on accepted start
//   start                       : one-cycle frame request (IDLE only)
//   busy / done                 : not-IDLE / one-cycle completion pulse
//   err_early_tlast, err_timeout: sticky error flags, cleared on start
//   frame_cnt                   : completed frames (wraps)
//   s_axis_*                    : DMA source stream
//   up_s_axis_*                 : stream into upsampler s00
//   up_m_axis_tvalid/tready/tlast : passive taps on upsampler m00
//   dbg_state                   : current sequencer state (state_t encoding)
//
// Handshake: a beat transfers on a cycle where tvalid and tready are both 1.
// During FEED the source and upsampler ports are wired straight through, so
// a source beat transfers exactly when the upsampler accepts it.
// -----------------------------------------------------------------------------
module upsample_frame_sched
   import upsample_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
   parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int V_SCALE        = DEF_V_SCALE,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CNT_WIDTH-1:0]  cfg_words_per_line,
   input  logic [CNT_WIDTH-1:0]  cfg_lines,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  err_early_tlast,
   output logic                  err_timeout,
   output logic [CNT_WIDTH-1:0]  frame_cnt,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] up_s_axis_tdata,
   output logic                  up_s_axis_tvalid,
   output logic                  up_s_axis_tlast,
   input  logic                  up_s_axis_tready,
   input  logic                  up_m_axis_tvalid,
   input  logic                  up_m_axis_tready,
   input  logic                  up_m_axis_tlast,
   output logic [1:0]            dbg_state
);

   localparam int OW = CNT_WIDTH + 2;
   localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] GAP_LAST = CNT_WIDTH'(GAP_CYCLES - 1);
   localparam logic [OW-1:0]        ONE_W    = OW'(1);
   localparam logic [OW-1:0]        V_SCALE_W = OW'(V_SCALE);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] wpl_q, wpl_d;
   logic [CNT_WIDTH-1:0] lines_q, lines_d;
   logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
   logic [CNT_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
   logic [OW-1:0]        out_line_cnt_q, out_line_cnt_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_early_q, err_early_d;
   logic                 err_timeout_q, err_timeout_d;

   logic          in_feed;
   logic          src_hs;
   logic          out_beat_last;
   logic          last_word;
   logic          last_line;
   logic          clear_cnt;
   logic [OW-1:0] out_line_target;

`ifdef DRAIN_TIMEOUT_EN
   localparam int            STALL_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [STALL_W-1:0] STALL_ONE   = STALL_W'(1);
   localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES);
   logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
`endif

   // Zero-latency data path; only the handshake signals are gated by state.
   assign in_feed          = (state_q == ST_FEED);
   assign up_s_axis_tdata  = s_axis_tdata;
   assign up_s_axis_tvalid = in_feed & s_axis_tvalid;
   assign s_axis_tready    = in_feed & up_s_axis_tready;
   assign up_s_axis_tlast  = in_feed & last_word;
   assign src_hs           = in_feed & s_axis_tvalid & up_s_axis_tready;
   assign out_beat_last    = up_m_axis_tvalid & up_m_axis_tready & up_m_axis_tlast;
   assign out_line_target  = OW'(lines_q) * V_SCALE_W;

   upsample_geom_cnt #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_geom (
      .clk            (clk),
      .rst_n          (rst_n),
      .clear          (clear_cnt),
      .advance        (src_hs),
      .words_per_line (wpl_q),
      .lines          (lines_q),
      .last_word      (last_word),
      .last_line      (last_line)
   );

   always_comb begin
      state_d        = state_q;
      wpl_d          = wpl_q;
      lines_d        = lines_q;
      frame_cnt_d    = frame_cnt_q;
      gap_cnt_d      = gap_cnt_q;
      out_line_cnt_d = out_line_cnt_q;
      done_d         = 1'b0;
      err_early_d    = err_early_q;
      err_timeout_d  = err_timeout_q;
      clear_cnt      = 1'b0;
`ifdef DRAIN_TIMEOUT_EN
      stall_cnt_d    = stall_cnt_q;
`endif

      // The upsampler may finish output lines while input is still flowing,
      // so output tlasts are counted from FEED entry, not just in DRAIN.
      if ((state_q == ST_FEED || state_q == ST_DRAIN) && out_beat_last) begin
         out_line_cnt_d = out_line_cnt_q + ONE_W;
      end

      case (state_q)
         ST_IDLE: begin
            // A start in the done cycle is not taken; the next cycle is.
            if (start && !done_q && cfg_words_per_line != '0 && cfg_lines != '0) begin
               wpl_d          = cfg_words_per_line;
               lines_d        = cfg_lines;
               clear_cnt      = 1'b1;
               out_line_cnt_d = '0;
               gap_cnt_d      = '0;
               err_early_d    = 1'b0;
               err_timeout_d  = 1'b0;
`ifdef DRAIN_TIMEOUT_EN
               stall_cnt_d    = '0;
`endif
               state_d        = ST_FEED;
            end
         end
         ST_FEED: begin
            if (src_hs) begin
               if (last_word && last_line) begin
                  state_d = ST_DRAIN;
               end else if (s_axis_tlast) begin
                  // Framing keeps following the programmed geometry.
                  err_early_d = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (out_line_cnt_d >= out_line_target) begin
               state_d   = ST_GAP;
               gap_cnt_d = '0;
            end
`ifdef DRAIN_TIMEOUT_EN
            else begin
               if (up_m_axis_tvalid && up_m_axis_tready) begin
                  stall_cnt_d = '0;
               end else begin
                  stall_cnt_d = stall_cnt_q + STALL_ONE;
               end
               if (stall_cnt_d == STALL_LIMIT) begin
                  err_timeout_d = 1'b1;
                  state_d       = ST_GAP;
                  gap_cnt_d     = '0;
               end
            end
`endif
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d     = ST_IDLE;
               done_d      = 1'b1;
               frame_cnt_d = frame_cnt_q + ONE;
            end else begin
               gap_cnt_d = gap_cnt_q + ONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy_d = (state_d != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         wpl_q          <= '0;
         lines_q        <= '0;
         frame_cnt_q    <= '0;
         gap_cnt_q      <= '0;
         out_line_cnt_q <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         err_early_q    <= 1'b0;
         err_timeout_q  <= 1'b0;
`ifdef DRAIN_TIMEOUT_EN
         stall_cnt_q    <= '0;
`endif
      end else begin
         state_q        <= state_d;
         wpl_q          <= wpl_d;
         lines_q        <= lines_d;
         frame_cnt_q    <= frame_cnt_d;
         gap_cnt_q      <= gap_cnt_d;
         out_line_cnt_q <= out_line_cnt_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         err_early_q    <= err_early_d;
         err_timeout_q  <= err_timeout_d;
`ifdef DRAIN_TIMEOUT_EN
         stall_cnt_q    <= stall_cnt_d;
`endif
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign err_early_tlast = err_early_q;
   assign frame_cnt       = frame_cnt_q;
   assign dbg_state       = state_q;
`ifdef DRAIN_TIMEOUT_EN
   assign err_timeout     = err_timeout_q;
`else
   assign err_timeout     = 1'b0;
   // Flag is only ever cleared without the timeout feature.
   logic unused_timeout;
   assign unused_timeout  = err_timeout_q;
`endif

endmodule

// File: tb/tb_upsample_frame_sched.sv
module tb_upsample_frame_sched;

   localparam int DW  = 32;
   localparam int CW  = 16;
   localparam int GAP = 20;
   localparam int VS  = 2;
   localparam int TMO = 64;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [CW-1:0] cfg_words_per_line, cfg_lines;
   logic          start;
   logic          busy, done, err_early_tlast, err_timeout;
   logic [CW-1:0] frame_cnt;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
   logic [DW-1:0] up_s_axis_tdata;
   logic          up_s_axis_tvalid, up_s_axis_tlast, up_s_axis_tready;
   logic          up_m_axis_tvalid, up_m_axis_tready, up_m_axis_tlast;
   logic [1:0]    dbg_state;

   upsample_frame_sched #(
      .DATA_WIDTH     (DW),
      .CNT_WIDTH      (CW),
      .GAP_CYCLES     (GAP),
      .V_SCALE        (VS),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .cfg_words_per_line (cfg_words_per_line),
      .cfg_lines          (cfg_lines),
      .start              (start),
      .busy               (busy),
      .done               (done),
      .err_early_tlast    (err_early_tlast),
      .err_timeout        (err_timeout),
      .frame_cnt          (frame_cnt),
      .s_axis_tdata       (s_axis_tdata),
      .s_axis_tvalid      (s_axis_tvalid),
      .s_axis_tlast       (s_axis_tlast),
      .s_axis_tready      (s_axis_tready),
      .up_s_axis_tdata    (up_s_axis_tdata),
      .up_s_axis_tvalid   (up_s_axis_tvalid),
      .up_s_axis_tlast    (up_s_axis_tlast),
      .up_s_axis_tready   (up_s_axis_tready),
      .up_m_axis_tvalid   (up_m_axis_tvalid),
      .up_m_axis_tready   (up_m_axis_tready),
      .up_m_axis_tlast    (up_m_axis_tlast),
      .dbg_state          (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [DW:0] exp_q[$];
   logic [DW:0] exp_w;
   int up_hs_cnt = 0;
   int up_tlast_cnt = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Upsampler-side monitor: each accepted word must match the oldest word the
   // source handed over, with tlast on every line boundary.
   always @(negedge clk) begin
      #2;
      if (rst_n && up_s_axis_tvalid && up_s_axis_tready) begin
         up_hs_cnt++;
         if (up_s_axis_tlast) up_tlast_cnt++;
         if (exp_q.size() == 0) begin
            check("up_extra_word", 64'd1, 64'd0);
         end else begin
            exp_w = exp_q.pop_front();
            check("up_word", {up_s_axis_tlast, up_s_axis_tdata}, exp_w);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_start(input int wpl, input int lines);
      @(posedge clk); #1;
      cfg_words_per_line = CW'(wpl);
      cfg_lines          = CW'(lines);
      start              = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic feed(input int n, input int wpl, input int tlast_at, input bit toggle,
                       input logic [DW-1:0] base, input logic [DW-1:0] inc);
      int idx = 0;
      int cyc = 0;
      logic [DW-1:0] w;
      @(posedge clk); #1;
      while (idx < n && cyc < 2000) begin
         w = base + inc * DW'(idx);
         s_axis_tdata     = w;
         s_axis_tvalid    = 1'b1;
         s_axis_tlast     = (idx == tlast_at);
         up_s_axis_tready = toggle ? cyc[0] : 1'b1;
         @(negedge clk);
         if (s_axis_tvalid && s_axis_tready) begin
            exp_q.push_back({((idx % wpl) == wpl - 1), w});
            idx++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (idx < n) check("feed_timeout", 64'(idx), 64'(n));
      s_axis_tlast     = 1'b0;
      up_s_axis_tready = 1'b1;
   endtask

   // Entered on the negedge of the first GAP cycle.
   task automatic wait_done(input logic [CW-1:0] exp_frames);
      int k = 0;
      while (!done && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("done_latency", 64'(k), 64'(GAP));
      check("frame_cnt", frame_cnt, exp_frames);
      @(negedge clk);
      check("done_one_cycle", done, 1'b0);
      check("idle_after_done", busy, 1'b0);
   endtask

   task automatic drain_out(input int nout, input logic [CW-1:0] exp_frames);
      for (int i = 0; i < nout; i++) begin
         up_m_axis_tvalid = 1'b1;
         up_m_axis_tready = 1'b1;
         up_m_axis_tlast  = 1'b1;
         @(posedge clk); #1;
         up_m_axis_tlast  = 1'b0;   // non-last beat: must not count
         @(negedge clk);
         if (i < nout - 1) check("still_drain", dbg_state, 2'd2);
         else              check("gap_entry", dbg_state, 2'd3);
         up_m_axis_tvalid = 1'b0;
         up_m_axis_tready = 1'b0;
      end
      wait_done(exp_frames);
   endtask

   task automatic run_frame(input int wpl, input int lines, input int tlast_at, input bit toggle,
                            input logic [DW-1:0] base, input logic [DW-1:0] inc,
                            input logic exp_err, input logic [CW-1:0] exp_frames,
                            input bit restart_in_feed);
      int hs0 = up_hs_cnt;
      int tl0 = up_tlast_cnt;
      do_start(wpl, lines);
      @(negedge clk);
      check("feed_entry", dbg_state, 2'd1);
      check("busy_in_feed", busy, 1'b1);
      if (restart_in_feed) begin
         do_start(1, 1);
         @(negedge clk);
         check("restart_ignored", dbg_state, 2'd1);
      end
      feed(wpl * lines, wpl, tlast_at, toggle, base, inc);
      @(negedge clk);
      check("src_ready_after_last", s_axis_tready, 1'b0);
      check("drain_state", dbg_state, 2'd2);
      check("up_words", 64'(up_hs_cnt - hs0), 64'(wpl * lines));
      check("up_tlasts", 64'(up_tlast_cnt - tl0), 64'(lines));
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      check("err_early", err_early_tlast, exp_err);
      s_axis_tvalid = 1'b0;
      drain_out(lines * VS, exp_frames);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      cfg_words_per_line = '0;
      cfg_lines          = '0;
      start              = 1'b0;
      s_axis_tdata       = '0;
      s_axis_tvalid      = 1'b0;
      s_axis_tlast       = 1'b0;
      up_s_axis_tready   = 1'b1;
      up_m_axis_tvalid   = 1'b0;
      up_m_axis_tready   = 1'b0;
      up_m_axis_tlast    = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_state", dbg_state, 2'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_src_ready", s_axis_tready, 1'b0);
      check("rst_up_valid", up_s_axis_tvalid, 1'b0);
      check("rst_up_last", up_s_axis_tlast, 1'b0);
      check("rst_err_early", err_early_tlast, 1'b0);
      check("rst_err_timeout", err_timeout, 1'b0);
      check("rst_frame_cnt", frame_cnt, 16'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // 4x2 frame, clean framing
      run_frame(4, 2, 7, 1'b0, 32'h1000_0000, 32'h1, 1'b0, 16'd1, 1'b0);
      // early source tlast on word 3
      run_frame(4, 2, 2, 1'b0, 32'h2000_0000, 32'h3, 1'b1, 16'd2, 1'b0);
      // upsampler ready toggling, pattern data
      run_frame(4, 2, 7, 1'b1, 32'h3322_1100, 32'h1111_1111, 1'b0, 16'd3, 1'b0);

      // start with zero line count is ignored
      s_axis_tvalid = 1'b1;
      do_start(4, 0);
      @(negedge clk);
      check("zero_cfg_busy", busy, 1'b0);
      check("zero_cfg_ready", s_axis_tready, 1'b0);
      repeat (2) @(negedge clk);
      check("zero_cfg_state", dbg_state, 2'd0);
      s_axis_tvalid = 1'b0;

      // start pulsed again during FEED is ignored
      run_frame(4, 2, 7, 1'b0, 32'h4000_0000, 32'h10, 1'b0, 16'd4, 1'b1);
      repeat (4) @(negedge clk);
      check("single_frame_count", frame_cnt, 16'd4);

      // reset after 3 of 8 words
      do_start(4, 2);
      feed(3, 4, 99, 1'b0, 32'h5000_0000, 32'h1);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_state", dbg_state, 2'd0);
      check("midrst_src_ready", s_axis_tready, 1'b0);
      check("midrst_up_valid", up_s_axis_tvalid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_frame_cnt", frame_cnt, 16'd0);
      s_axis_tvalid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_frame(4, 2, 7, 1'b0, 32'h6000_0000, 32'h7, 1'b0, 16'd1, 1'b0);

`ifdef DRAIN_TIMEOUT_EN
      begin
         int k = 0;
         do_start(2, 1);
         feed(2, 2, 1, 1'b0, 32'h7000_0000, 32'h1);
         s_axis_tvalid = 1'b0;
         while (k < 500) begin
            @(negedge clk);
            if (dbg_state == 2'd2) k++;
            else break;
         end
         check("timeout_cycles", 64'(k), 64'(TMO));
         check("timeout_gap", dbg_state, 2'd3);
         check("err_timeout", err_timeout, 1'b1);
         wait_done(16'd2);
      end
`else
      check("err_timeout_tied", err_timeout, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
